rob_param: RTL and testbench

//  Parametrised circular reorder buffer for the out-of-order RV32I core. Allocates one entry per

---
 rtl/rob_param.sv | 257 +++++++++++++++++++++++++
 tb/tb_rob_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// Reorder buffer for the out-of-order RV32I core.
// Circular buffer of DEPTH entries. Entries are allocated at the tail by the dispatcher, completed
// by CDB broadcasts, and retired from the head strictly in program order. A branch whose resolved
// direction disagrees with the prediction, or any jalr, raises a one-cycle flush after it retires.
// Optional build macro: ROB_QUERY_EN adds two combinational operand-lookup ports.
module rob_param #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   // dispatch
   input  logic             issue_en,
   input  logic [1:0]       issue_type,
   input  logic [4:0]       issue_rd,
   input  logic [31:0]      issue_pc,
   input  logic             issue_pred,
   output logic [TAG_W-1:0] issue_tag,
   output logic             full,
   // common data bus
   input  logic             cdb_en,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_val,
   input  logic             cdb_taken,
   input  logic [31:0]      cdb_target,
`ifdef ROB_QUERY_EN
   // operand lookup
   input  logic [TAG_W-1:0] q1_tag,
   input  logic [TAG_W-1:0] q2_tag,
   output logic             q1_rdy,
   output logic             q2_rdy,
   output logic [31:0]      q1_val,
   output logic [31:0]      q2_val,
`endif
   // retirement
   output logic             commit_rf_en,
   output logic [4:0]       commit_rd,
   output logic [31:0]      commit_val,
   output logic [TAG_W-1:0] commit_tag,
   output logic             commit_st_en,
   output logic             bp_upd_en,
   output logic [31:0]      bp_upd_pc,
   output logic             bp_upd_taken,
   output logic             flush,
   output logic [31:0]      flush_pc
);

   localparam logic [1:0] TypeReg    = 2'd0;
   localparam logic [1:0] TypeBranch = 2'd1;
   localparam logic [1:0] TypeStore  = 2'd2;
   localparam logic [1:0] TypeJalr   = 2'd3;

   localparam logic [TAG_W:0] FullCount = (TAG_W+1)'(DEPTH);

   // Pointer and occupancy state
   logic [TAG_W-1:0] head_q, head_d;
   logic [TAG_W-1:0] tail_q, tail_d;
   logic [TAG_W:0]   count_q, count_d;
   logic [DEPTH-1:0] ready_q, ready_d;

   // Entry payload; only meaningful while the matching slot is occupied
   logic [1:0]  type_q   [DEPTH];
   logic [4:0]  rd_q     [DEPTH];
   logic [31:0] pc_q     [DEPTH];
   logic        pred_q   [DEPTH];
   logic [31:0] val_q    [DEPTH];
   logic        taken_q  [DEPTH];
   logic [31:0] target_q [DEPTH];

   // Registered retirement outputs
   logic             rf_en_q, rf_en_d;
   logic             st_en_q, st_en_d;
   logic             bp_en_q, bp_en_d;
   logic             flush_q, flush_d;
   logic [4:0]       commit_rd_q;
   logic [31:0]      commit_val_q;
   logic [TAG_W-1:0] commit_tag_q;
   logic [31:0]      bp_pc_q;
   logic             bp_taken_q;
   logic [31:0]      flush_pc_q, flush_pc_d;

   // Head entry view
   logic [1:0]  h_type;
   logic [4:0]  h_rd;
   logic [31:0] h_pc;
   logic        h_pred;
   logic        h_taken;
   logic [31:0] h_target;

   logic issue_ok;
   logic cdb_ok;
   logic commit_ok;
   logic mispredict;
   logic do_flush;

   assign full      = (count_q == FullCount);
   assign issue_tag = tail_q;

   assign h_type   = type_q[head_q];
   assign h_rd     = rd_q[head_q];
   assign h_pc     = pc_q[head_q];
   assign h_pred   = pred_q[head_q];
   assign h_taken  = taken_q[head_q];
   assign h_target = target_q[head_q];

   // The flush cycle swallows dispatch and CDB traffic; the buffer is already empty by then.
   assign issue_ok  = issue_en && !full && rdy && !flush_q;
   assign cdb_ok    = cdb_en && rdy && !flush_q;
   assign commit_ok = rdy && !flush_q && (count_q != '0) && ready_q[head_q];

   assign mispredict = ((h_type == TypeBranch) && (h_taken != h_pred)) || (h_type == TypeJalr);
   assign do_flush   = commit_ok && mispredict;

   // Next-state for pointers, occupancy and ready bits
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ready_d = ready_q;
      if (cdb_ok) begin
         ready_d[cdb_tag] = 1'b1;
      end
      if (issue_ok) begin
         ready_d[tail_q] = 1'b0;
         tail_d          = tail_q + 1'b1;
      end
      if (commit_ok) begin
         head_d = head_q + 1'b1;
      end
      unique case ({issue_ok, commit_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A mispredict discards everything younger, including a same-cycle allocation
      if (do_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         ready_d = '0;
      end
   end

   // Next-state for the retirement pulses and the redirect target
   always_comb begin
      rf_en_d    = 1'b0;
      st_en_d    = 1'b0;
      bp_en_d    = 1'b0;
      flush_d    = do_flush;
      flush_pc_d = flush_pc_q;
      if (commit_ok) begin
         unique case (h_type)
            TypeReg, TypeJalr: rf_en_d = (h_rd != 5'd0);
            TypeStore:         st_en_d = 1'b1;
            TypeBranch:        bp_en_d = 1'b1;
            default:           ;
         endcase
      end
      if (do_flush) begin
         if (h_type == TypeJalr) begin
            flush_pc_d = h_target;
         end else begin
            flush_pc_d = h_taken ? h_target : (h_pc + 32'd4);
         end
      end
   end

   // Control state register; everything holds while rdy is low
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ready_q <= '0;
      end else if (rdy) begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ready_q <= ready_d;
      end
   end

   // Entry payload writes from dispatch and from the CDB
   always_ff @(posedge clk) begin
      if (issue_ok) begin
         type_q[tail_q] <= issue_type;
         rd_q[tail_q]   <= issue_rd;
         pc_q[tail_q]   <= issue_pc;
         pred_q[tail_q] <= issue_pred;
      end
      if (cdb_ok) begin
         val_q[cdb_tag]    <= cdb_val;
         taken_q[cdb_tag]  <= cdb_taken;
         target_q[cdb_tag] <= cdb_target;
      end
   end

   // Retirement output registers; pulses hold while rdy is low and are masked at the port
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_en_q      <= 1'b0;
         st_en_q      <= 1'b0;
         bp_en_q      <= 1'b0;
         flush_q      <= 1'b0;
         commit_rd_q  <= '0;
         commit_val_q <= '0;
         commit_tag_q <= '0;
         bp_pc_q      <= '0;
         bp_taken_q   <= 1'b0;
         flush_pc_q   <= '0;
      end else if (rdy) begin
         rf_en_q    <= rf_en_d;
         st_en_q    <= st_en_d;
         bp_en_q    <= bp_en_d;
         flush_q    <= flush_d;
         flush_pc_q <= flush_pc_d;
         if (commit_ok) begin
            commit_rd_q  <= h_rd;
            commit_val_q <= val_q[head_q];
            commit_tag_q <= head_q;
            bp_pc_q      <= h_pc;
            bp_taken_q   <= h_taken;
         end
      end
   end

   assign commit_rf_en = rf_en_q & rdy;
   assign commit_st_en = st_en_q & rdy;
   assign bp_upd_en    = bp_en_q & rdy;
   assign flush        = flush_q & rdy;
   assign commit_rd    = commit_rd_q;
   assign commit_val   = commit_val_q;
   assign commit_tag   = commit_tag_q;
   assign bp_upd_pc    = bp_pc_q;
   assign bp_upd_taken = bp_taken_q;
   assign flush_pc     = flush_pc_q;

`ifdef ROB_QUERY_EN
   // Operand lookup, forwarding a same-cycle broadcast to the queried entry
   always_comb begin
      q1_rdy = ready_q[q1_tag];
      q1_val = val_q[q1_tag];
      q2_rdy = ready_q[q2_tag];
      q2_val = val_q[q2_tag];
      if (cdb_en && (cdb_tag == q1_tag)) begin
         q1_rdy = 1'b1;
         q1_val = cdb_val;
      end
      if (cdb_en && (cdb_tag == q2_tag)) begin
         q2_rdy = 1'b1;
         q2_val = cdb_val;
      end
   end
`endif

endmodule

// File: tb/tb_rob_param.sv
// Randomized bench for rob_param against a queue-based model of in-order retirement.
module tb_rob_param;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned TAG_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, rdy;
   logic             issue_en;
   logic [1:0]       issue_type;
   logic [4:0]       issue_rd;
   logic [31:0]      issue_pc;
   logic             issue_pred;
   logic [TAG_W-1:0] issue_tag;
   logic             full;
   logic             cdb_en;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_val;
   logic             cdb_taken;
   logic [31:0]      cdb_target;
   logic             commit_rf_en;
   logic [4:0]       commit_rd;
   logic [31:0]      commit_val;
   logic [TAG_W-1:0] commit_tag;
   logic             commit_st_en;
   logic             bp_upd_en;
   logic [31:0]      bp_upd_pc;
   logic             bp_upd_taken;
   logic             flush;
   logic [31:0]      flush_pc;
`ifdef ROB_QUERY_EN
   logic [TAG_W-1:0] q1_tag, q2_tag;
   logic             q1_rdy, q2_rdy;
   logic [31:0]      q1_val, q2_val;
`endif

   rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .issue_en     (issue_en),
      .issue_type   (issue_type),
      .issue_rd     (issue_rd),
      .issue_pc     (issue_pc),
      .issue_pred   (issue_pred),
      .issue_tag    (issue_tag),
      .full         (full),
      .cdb_en       (cdb_en),
      .cdb_tag      (cdb_tag),
      .cdb_val      (cdb_val),
      .cdb_taken    (cdb_taken),
      .cdb_target   (cdb_target),
`ifdef ROB_QUERY_EN
      .q1_tag       (q1_tag),
      .q2_tag       (q2_tag),
      .q1_rdy       (q1_rdy),
      .q2_rdy       (q2_rdy),
      .q1_val       (q1_val),
      .q2_val       (q2_val),
`endif
      .commit_rf_en (commit_rf_en),
      .commit_rd    (commit_rd),
      .commit_val   (commit_val),
      .commit_tag   (commit_tag),
      .commit_st_en (commit_st_en),
      .bp_upd_en    (bp_upd_en),
      .bp_upd_pc    (bp_upd_pc),
      .bp_upd_taken (bp_upd_taken),
      .flush        (flush),
      .flush_pc     (flush_pc)
   );

   // Model: live instructions in program order, oldest first
   typedef struct {
      int          typ;
      int          rd;
      logic [31:0] pc;
      bit          pred;
      int          tag;
      bit          done;
      logic [31:0] val;
      bit          taken;
      logic [31:0] target;
   } ent_t;

   ent_t        rob[$];
   int          next_tag;
   bit          flush_pend;
   bit          e_rf, e_st, e_bp, e_fl, e_bp_taken;
   int          e_rd, e_tag;
   logic [31:0] e_val, e_bp_pc, e_fl_pc;

   int total, bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_step();
      bit          do_commit, do_issue, misp;
      logic [31:0] fpc;
      ent_t        e, n;
      if (rst) begin
         rob.delete();
         next_tag = 0; flush_pend = 0;
         e_rf = 0; e_st = 0; e_bp = 0; e_fl = 0; e_bp_taken = 0;
         e_rd = 0; e_tag = 0; e_val = 0; e_bp_pc = 0; e_fl_pc = 0;
         return;
      end
      if (!rdy) return;
      e_rf = 0; e_st = 0; e_bp = 0; e_fl = 0;
      if (flush_pend) begin
         flush_pend = 0;
         return;
      end
      do_commit = (rob.size() > 0) && rob[0].done;
      do_issue  = issue_en && (rob.size() < DEPTH);
      misp = 0; fpc = 0;
      if (cdb_en) begin
         foreach (rob[i]) begin
            if (rob[i].tag == int'(cdb_tag)) begin
               rob[i].done = 1; rob[i].val = cdb_val;
               rob[i].taken = cdb_taken; rob[i].target = cdb_target;
            end
         end
      end
      if (do_commit) begin
         e = rob.pop_front();
         e_rd = e.rd; e_val = e.val; e_tag = e.tag;
         case (e.typ)
            0: e_rf = (e.rd != 0);
            1: begin
               e_bp = 1; e_bp_pc = e.pc; e_bp_taken = e.taken;
               if (e.taken != e.pred) begin
                  misp = 1;
                  fpc = e.taken ? e.target : e.pc + 32'd4;
               end
            end
            2: e_st = 1;
            default: begin
               e_rf = (e.rd != 0); misp = 1; fpc = e.target;
            end
         endcase
      end
      if (do_issue) begin
         n.typ = int'(issue_type); n.rd = int'(issue_rd); n.pc = issue_pc;
         n.pred = issue_pred; n.tag = next_tag; n.done = 0;
         n.val = 0; n.taken = 0; n.target = 0;
         rob.push_back(n);
         next_tag = (next_tag + 1) % DEPTH;
      end
      if (misp) begin
         rob.delete();
         next_tag = 0; flush_pend = 1; e_fl = 1; e_fl_pc = fpc;
      end
   endtask

   task automatic check_outputs();
      check("full", full, rob.size() == DEPTH);
      check("issue_tag", issue_tag, next_tag);
      check("commit_rf_en", commit_rf_en, e_rf & rdy);
      check("commit_st_en", commit_st_en, e_st & rdy);
      check("bp_upd_en", bp_upd_en, e_bp & rdy);
      check("flush", flush, e_fl & rdy);
      if (e_rf && rdy) begin
         check("commit_rd", commit_rd, e_rd);
         check("commit_val", commit_val, e_val);
         check("commit_tag", commit_tag, e_tag);
      end
      if (e_bp && rdy) begin
         check("bp_upd_pc", bp_upd_pc, e_bp_pc);
         check("bp_upd_taken", bp_upd_taken, e_bp_taken);
      end
      if (e_fl && rdy) check("flush_pc", flush_pc, e_fl_pc);
   endtask

   task automatic drive_random(input int issue_pct, input int cdb_pct, input int rdy_pct);
      int cand[$];
      int r, idx;
      rdy        = ($urandom_range(99) < rdy_pct);
      issue_en   = ($urandom_range(99) < issue_pct);
      r          = $urandom_range(15);
      issue_type = (r < 8) ? 2'd0 : (r < 12) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      issue_rd   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      issue_pc   = $urandom & 32'hffff_fffc;
      issue_pred = 1'($urandom_range(1));
      cdb_en     = 0;
      cdb_tag    = TAG_W'($urandom_range(DEPTH - 1));
      cdb_val    = $urandom;
      cdb_taken  = 1'($urandom_range(1));
      cdb_target = $urandom & 32'hffff_fffc;
      foreach (rob[i]) if (!rob[i].done) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(99) < cdb_pct) begin
         idx     = cand[$urandom_range(cand.size() - 1)];
         cdb_en  = 1;
         cdb_tag = TAG_W'(rob[idx].tag);
         // most branches resolve as predicted so younger work gets to retire
         if (rob[idx].typ == 1)
            cdb_taken = ($urandom_range(4) == 0) ? !rob[idx].pred : rob[idx].pred;
      end else if (rob.size() == 0 && $urandom_range(4) == 0) begin
         cdb_en = 1;
      end
   endtask

`ifdef ROB_QUERY_EN
   task automatic check_query(input string nm, input logic [TAG_W-1:0] t, input logic r,
                              input logic [31:0] v);
      if (cdb_en && cdb_tag == t) begin
         check({nm, "_rdy_fwd"}, r, 1'b1);
         check({nm, "_val_fwd"}, v, cdb_val);
      end else begin
         foreach (rob[i]) begin
            if (rob[i].tag == int'(t)) begin
               check({nm, "_rdy"}, r, rob[i].done);
               if (rob[i].done) check({nm, "_val"}, v, rob[i].val);
            end
         end
      end
   endtask
`endif

   initial begin
      total = 0; bad = 0;
      rst = 1; rdy = 1; issue_en = 0; issue_type = 0; issue_rd = 0; issue_pc = 0;
      issue_pred = 0; cdb_en = 0; cdb_tag = 0; cdb_val = 0; cdb_taken = 0; cdb_target = 0;
`ifdef ROB_QUERY_EN
      q1_tag = 0; q2_tag = 0;
`endif
      model_step();
      @(negedge clk);
      // reset state: every output zero
      check_outputs();
      check("rst_commit_rd", commit_rd, 0);
      check("rst_commit_val", commit_val, 0);
      check("rst_commit_tag", commit_tag, 0);
      check("rst_bp_upd_pc", bp_upd_pc, 0);
      check("rst_bp_upd_taken", bp_upd_taken, 0);
      check("rst_flush_pc", flush_pc, 0);

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         check_outputs();
         if (cyc < 60) drive_random(100, 0, 100);          // fill to full, then hammer issue
         else if (cyc < 200) drive_random(90, 30, 100);    // run near the full boundary
         else drive_random(60, 50, 85);
         rst = (cyc == 2500 || cyc == 2501);
`ifdef ROB_QUERY_EN
         q1_tag = ($urandom_range(1) == 0) ? cdb_tag : TAG_W'($urandom_range(DEPTH - 1));
         q2_tag = TAG_W'($urandom_range(DEPTH - 1));
         #1;
         check_query("q1", q1_tag, q1_rdy, q1_val);
         check_query("q2", q2_tag, q2_rdy, q2_val);
`endif
         model_step();
      end
      @(negedge clk);
      check_outputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
